frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Run-level controller for the acoustic front end. On a start command it flushes and enables the framing buffer and the FFT stage, counts completed frames against a programmed utterance length, drains the FFT, and then signals completion. It also tracks samples pending inside the framing FIFO and aborts with a sticky error if that FIFO would overrun. It sits between the top-level wake controller and the `framing`/FFT enables.

## Interface
- `FRAME_LEN`, 256: samples per frame; must match the framing instance.
- `FIFO_DEPTH`, 260: framing FIFO depth (FRAME_LEN + 4).
- `NUM_FRAMES`, 50: frames per run.
- `SETTLE_CYC`, 4: cycles the enables are held low in ARM to flush downstream state.
- `DRAIN_CYC`, 64: cycles `fft_en_o` stays high after the last frame.
- `clk_i` in 1: the single clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: start pulse. Accepted in IDLE or ERR only; ignored elsewhere.
- `stop_i` in 1: abort. Has priority over `start_i` in every state.
- `sample_valid_i` in 1: sample strobe into framing (preemphasis `valid`).
- `frame_last_i` in 1: framing `last_o`, one pulse per completed frame.
- `framing_en_o` out 1: framing enable.
- `fft_en_o` out 1: FFT enable.
- `frame_idx_o` out clog2(NUM_FRAMES+1): frames completed in the current run.
- `busy_o` out 1: high in ARM, RUN, DRAIN.
- `done_o` out 1: one-cycle pulse on normal completion.
- `abort_o` out 1: one-cycle pulse when `stop_i` ends a non-IDLE run.
- `err_o` out 1: sticky overrun flag.

## Operation
- States: IDLE, ARM, RUN, DRAIN, DONE, ERR. All outputs are registered.
- **IDLE**
  - `start_i` → ARM.
  - On that edge, clear `frame_idx_o`, the pending counter and the settle/drain counter.
- **ARM**
  - Both enables are 0.
  - After SETTLE_CYC cycles → RUN.
- **RUN**
  - `framing_en_o` = 1 and `fft_en_o` = 1.
  - Each `frame_last_i` increments `frame_idx_o`.
  - A `frame_last_i` when `frame_idx_o` == NUM_FRAMES-1 → DRAIN.
- **DRAIN**
  - `framing_en_o` = 0 and `fft_en_o` = 1.
  - After DRAIN_CYC cycles → DONE.
  - `frame_last_i` is ignored.
- **DONE**
  - One cycle, `done_o` = 1, then → IDLE.
  - `frame_idx_o` holds NUM_FRAMES until the next accepted start.
- **ERR**
  - Both enables are 0 and `err_o` = 1.
  - `start_i` → ARM and clears `err_o`.
  - `stop_i` → IDLE and clears `err_o`.
- **stop_i**
  - In ARM, RUN, DRAIN or DONE: next state is IDLE, enables drop at that edge, and `abort_o` pulses for 1 cycle.
  - In ERR: next state is IDLE and `err_o` clears; `abort_o` does not pulse.
  - In IDLE: no effect.
- **Pending counter**
  - Width clog2(FIFO_DEPTH+1)+1, unsigned.
  - Active only in RUN; it is not updated in any other state.
  - +1 on `sample_valid_i`; −FRAME_LEN on `frame_last_i`; both in the same cycle give +1−FRAME_LEN.
  - If `frame_last_i` arrives with pending < FRAME_LEN, the counter saturates at 0 (underflow).
  - If the next value would exceed FIFO_DEPTH → ERR, `err_o` = 1, enables drop.
  - Overrun has priority over a same-cycle frame-count completion, but not over `stop_i`.

## Timing
- Reset (asynchronous assert):
  - state = IDLE.
  - All outputs = 0, including `frame_idx_o`, `err_o` and both enables.
  - All counters = 0.
- Start latency: with `start_i` at edge N, `busy_o` = 1 from N+1 and both enables = 1 from N+1+SETTLE_CYC.
- End of run: `frame_last_i` completing frame NUM_FRAMES at edge M gives:
  - `framing_en_o` = 0 from M+1;
  - `fft_en_o` = 0 and `done_o` = 1 at M+1+DRAIN_CYC;
  - IDLE at M+2+DRAIN_CYC.
- Enable edges coincide with the state-register update; no combinational path from inputs to outputs.
- `start_i` held high: accepted once per IDLE/ERR visit, so a held start re-arms immediately after DONE→IDLE.

## Test plan
- **Normal run.** Reset, then start with NUM_FRAMES=3, FRAME_LEN=8, SETTLE_CYC=4, DRAIN_CYC=5. Drive `sample_valid_i` every 2 cycles and `frame_last_i` after each 8 samples.
  - Enables rise 5 cycles after start.
  - `frame_idx_o` steps 1, 2, 3.
  - `fft_en_o` stays high 5 cycles past `framing_en_o`.
  - One `done_o` pulse, then IDLE.
- **Overrun.** FIFO_DEPTH=12, FRAME_LEN=8, no `frame_last_i`: on the 13th sample `err_o` = 1 next edge and both enables = 0. A later `start_i` clears `err_o` and re-arms.
- **Simultaneous sample and last.** Pending = 8, then `sample_valid_i` and `frame_last_i` in one cycle → pending = 1, no error.
- **Abort.** `stop_i` during RUN at frame 1 gives:
  - `abort_o` 1-cycle pulse and enables 0 next edge;
  - `done_o` never asserts;
  - `frame_idx_o` holds 1 until the next start.
- **Start priority, spurious lasts, reset.**
  - `start_i` and `stop_i` together in IDLE → stays IDLE.
  - `frame_last_i` during ARM/DRAIN does not change `frame_idx_o`.
  - `rst_n_i` low mid-RUN drops all outputs within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/frame_sequencer.sv
// frame_sequencer: run-level controller for the acoustic front end.
// Sequences framing/FFT enables over one utterance and guards the framing FIFO.
module frame_sequencer #(
  parameter int FRAME_LEN  = 256,
  parameter int FIFO_DEPTH = 260,
  parameter int NUM_FRAMES = 50,
  parameter int SETTLE_CYC = 4,
  parameter int DRAIN_CYC  = 64,
  localparam int IW = $clog2(NUM_FRAMES + 1),
  localparam int PW = $clog2(FIFO_DEPTH + 1) + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          start_i,
  input  logic          stop_i,
  input  logic          sample_valid_i,
  input  logic          frame_last_i,
  output logic          framing_en_o,
  output logic          fft_en_o,
  output logic [IW-1:0] frame_idx_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          abort_o,
  output logic          err_o
);

  localparam int CMAX = (SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pend_q, pend_d;
  logic [IW-1:0] idx_q, idx_d;
  logic abort_d;

  logic [PW-1:0] pend_sum;
  logic [PW-1:0] pend_nx;
  logic overrun;

  // Underflow on a frame boundary saturates at zero.
  always_comb begin
    pend_sum = pend_q + PW'(sample_valid_i);
    pend_nx  = pend_sum;
    if (frame_last_i) begin
      if (pend_sum < PW'(FRAME_LEN)) pend_nx = '0;
      else pend_nx = pend_sum - PW'(FRAME_LEN);
    end
    overrun = pend_nx > PW'(FIFO_DEPTH);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    abort_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!stop_i && start_i) begin
          state_d = S_ARM;
          cnt_d   = '0;
          pend_d  = '0;
          idx_d   = '0;
        end
      end
      S_ARM: begin
        if (stop_i) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (overrun) begin
          state_d = S_ERR;
        end else begin
          pend_d = pend_nx;
          if (frame_last_i) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == IW'(NUM_FRAMES - 1)) begin
              state_d = S_DRAIN;
              cnt_d   = '0;
            end
          end
        end
      end
      S_DRAIN: begin
        if (stop_i) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == CW'(DRAIN_CYC - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        abort_d = stop_i;
      end
      S_ERR: begin
        if (stop_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          state_d = S_ARM;
          cnt_d   = '0;
          pend_d  = '0;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they switch with it.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      idx_q        <= '0;
      framing_en_o <= 1'b0;
      fft_en_o     <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      abort_o      <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      idx_q        <= idx_d;
      framing_en_o <= (state_d == S_RUN);
      fft_en_o     <= (state_d == S_RUN) || (state_d == S_DRAIN);
      busy_o       <= (state_d == S_ARM) || (state_d == S_RUN) ||
                      (state_d == S_DRAIN);
      done_o       <= (state_d == S_DONE);
      abort_o      <= abort_d;
      err_o        <= (state_d == S_ERR);
    end
  end

  assign frame_idx_o = idx_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed checks of frame_sequencer with a small config.
// Expected values are hand-derived from the run timing.
module tb_frame_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic stop = 1'b0;
  logic valid = 1'b0;
  logic last = 1'b0;
  logic framing_en, fft_en, busy, done, abort_p, err;
  logic [1:0] frame_idx;

  int checks = 0;
  int errors = 0;

  frame_sequencer #(
    .FRAME_LEN(8),
    .FIFO_DEPTH(12),
    .NUM_FRAMES(3),
    .SETTLE_CYC(4),
    .DRAIN_CYC(5)
  ) dut (
    .clk_i(clk),
    .rst_n_i(rst_n),
    .start_i(start),
    .stop_i(stop),
    .sample_valid_i(valid),
    .frame_last_i(last),
    .framing_en_o(framing_en),
    .fft_en_o(fft_en),
    .frame_idx_o(frame_idx),
    .busy_o(busy),
    .done_o(done),
    .abort_o(abort_p),
    .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // reset
    #1;
    chk("rst_fr_en", framing_en, 0);
    chk("rst_fft_en", fft_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", frame_idx, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("idle_busy", busy, 0);

    // normal run
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("arm_busy", busy, 1);
    chk("arm_fr_en", framing_en, 0);
    repeat (3) cyc();
    chk("arm_late_fft", fft_en, 0);
    cyc();
    chk("run_fr_en", framing_en, 1);
    chk("run_fft_en", fft_en, 1);
    for (int f = 1; f <= 3; f++) begin
      for (int s = 0; s < 8; s++) begin
        valid = 1'b1;
        cyc();
        valid = 1'b0;
        cyc();
      end
      last = 1'b1;
      cyc();
      last = 1'b0;
      chk("frame_idx", frame_idx, f);
      chk("frame_err", err, 0);
      if (f < 3) chk("mid_fr_en", framing_en, 1);
    end
    chk("drain_fr_en", framing_en, 0);
    chk("drain_fft_en", fft_en, 1);
    last = 1'b1;
    cyc();
    last = 1'b0;
    chk("drain_spur_idx", frame_idx, 3);
    repeat (3) cyc();
    chk("drain_end_fft", fft_en, 1);
    chk("drain_end_done", done, 0);
    cyc();
    chk("done_pulse", done, 1);
    chk("done_fft", fft_en, 0);
    chk("done_busy", busy, 0);
    chk("done_idx", frame_idx, 3);
    cyc();
    chk("done_clear", done, 0);
    chk("post_idx", frame_idx, 3);

    // overrun, with a spurious last in ARM
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("restart_idx", frame_idx, 0);
    last = 1'b1;
    cyc();
    last = 1'b0;
    chk("arm_spur_idx", frame_idx, 0);
    repeat (3) cyc();
    chk("ovr_run_en", framing_en, 1);
    valid = 1'b1;
    repeat (12) cyc();
    chk("ovr_12_err", err, 0);
    chk("ovr_12_en", framing_en, 1);
    cyc();
    valid = 1'b0;
    chk("ovr_13_err", err, 1);
    chk("ovr_13_fr", framing_en, 0);
    chk("ovr_13_fft", fft_en, 0);
    chk("ovr_13_busy", busy, 0);
    cyc();
    chk("err_sticky", err, 1);
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("err_restart", err, 0);
    chk("err_rearm", busy, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("arm_abort", abort_p, 1);
    chk("arm_abort_busy", busy, 0);
    cyc();
    chk("abort_1cyc", abort_p, 0);

    // simultaneous sample and last
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    valid = 1'b1;
    repeat (8) cyc();
    last = 1'b1;
    cyc();
    last = 1'b0;
    valid = 1'b0;
    chk("sim_idx", frame_idx, 1);
    chk("sim_err", err, 0);
    valid = 1'b1;
    repeat (11) cyc();
    chk("sim_11_err", err, 0);
    cyc();
    valid = 1'b0;
    chk("sim_12_err", err, 1);
    chk("sim_err_idx", frame_idx, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("err_stop_err", err, 0);
    chk("err_stop_abort", abort_p, 0);
    chk("err_stop_busy", busy, 0);

    // underflow saturation then abort in RUN
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    last = 1'b1;
    cyc();
    last = 1'b0;
    chk("uf_idx", frame_idx, 1);
    valid = 1'b1;
    repeat (12) cyc();
    valid = 1'b0;
    chk("uf_err", err, 0);
    chk("uf_fr_en", framing_en, 1);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("run_abort", abort_p, 1);
    chk("run_abort_fr", framing_en, 0);
    chk("run_abort_fft", fft_en, 0);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("abort_no_done", done, 0);
    end
    chk("abort_pulse_end", abort_p, 0);
    chk("abort_idx_hold", frame_idx, 1);

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    cyc();
    start = 1'b0;
    stop = 1'b0;
    chk("ss_busy", busy, 0);
    chk("ss_abort", abort_p, 0);
    chk("ss_idx", frame_idx, 1);

    // asynchronous reset mid-RUN
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (4) cyc();
    last = 1'b1;
    cyc();
    last = 1'b0;
    chk("pre_rst_idx", frame_idx, 1);
    chk("pre_rst_en", framing_en, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_fr", framing_en, 0);
    chk("arst_fft", fft_en, 0);
    chk("arst_busy", busy, 0);
    chk("arst_idx", frame_idx, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
